pipe_ctrl_unit: RTL and testbench

Pipelined control unit for the 5-stage RV32I core. It decodes the instruction in ID into EX, MEM and WB control bundles and carries each bundle, with its destination register, through the ID/EX, EX/MEM and MEM/WB control registers. It inserts bubbles for invalid slots, load-use hazards and taken-branch flushes, and freezes on an external stall. It is the successor to the core's combinational decoder, adding decode, per-stage control registers and hazard handling.

---
 rtl/pipe_ctrl_unit.sv | 168 ++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: pipelined control unit for the 5-stage RV32I core.
// Decodes the ID instruction into EX/MEM/WB control bundles and carries them,
// with the destination register, through the ID/EX, EX/MEM and MEM/WB
// control registers. Inserts bubbles for invalid slots, load-use hazards and
// taken-branch flushes; freezes on an external stall.
//
// Optional feature macro: HAZARD_DETECT_EN (load-use detection). When it is
// undefined, hazard_stall is tied low and no comparators are built.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-high reset, clears all state
//   inst          instruction in ID (bits [31:0] decoded)
//   inst_valid    inst holds a real instruction; 0 inserts a bubble
//   stall_in      external freeze; all control registers hold
//   branch_taken  branch in MEM taken; squashes ID and EX
//   ex_ctrl       {AluSrc, AluOp[1:0]} for the instruction in EX
//   mem_ctrl      {MemRead, MemWrite, Branch} for the instruction in MEM
//   wb_ctrl       {MemtoReg, RegWrite} for the instruction in WB
//   ex_rd/mem_rd/wb_rd  destination register per stage
//   hazard_stall  combinational load-use stall request for PC and IF/ID
//   flush_ifid    combinational branch_taken gated by !stall_in
//   illegal_id    combinational: valid instruction with unsupported opcode
module pipe_ctrl_unit #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned ILEN   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ILEN-1:0]   inst,
  input  logic              inst_valid,
  input  logic              stall_in,
  input  logic              branch_taken,
  output logic [2:0]        ex_ctrl,
  output logic [2:0]        mem_ctrl,
  output logic [1:0]        wb_ctrl,
  output logic [REG_AW-1:0] ex_rd,
  output logic [REG_AW-1:0] mem_rd,
  output logic [REG_AW-1:0] wb_rd,
  output logic              hazard_stall,
  output logic              flush_ifid,
  output logic              illegal_id
);

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I      = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011
  } opcode_e;

  logic [6:0]        opcode;
  logic [REG_AW-1:0] rd_field;
  logic              legal_op;

  // Decoded bundle for the ID instruction; all-zero (rd included) for bubbles.
  logic [2:0]        id_ex;
  logic [2:0]        id_m;
  logic [1:0]        id_wb;
  logic [REG_AW-1:0] id_rd;

  // Pipeline state not visible on the ports.
  logic [2:0]        idex_m;
  logic [1:0]        idex_wb;
  logic [1:0]        exmem_wb;

  // Fields outside the decoded ranges are intentionally ignored.
  logic unused_inst_bits;
  assign unused_inst_bits = ^inst;

  assign opcode   = inst[6:0];
  assign rd_field = inst[7 +: REG_AW];

  always_comb begin
    id_ex    = '0;
    id_m     = '0;
    id_wb    = '0;
    id_rd    = '0;
    legal_op = 1'b1;
    case (opcode)
      OP_R:      begin id_ex = 3'b010; id_wb = 2'b01; end
      OP_I:      begin id_ex = 3'b110; id_wb = 2'b01; end
      OP_LOAD:   begin id_ex = 3'b100; id_m = 3'b100; id_wb = 2'b11; end
      OP_STORE:  begin id_ex = 3'b100; id_m = 3'b010; end
      OP_BRANCH: begin id_ex = 3'b001; id_m = 3'b001; end
      default:   legal_op = 1'b0;
    endcase
    if (legal_op) begin
      id_rd = rd_field;
      if (rd_field == '0) id_wb[0] = 1'b0;
    end
    if (!inst_valid || !legal_op) begin
      id_ex = '0;
      id_m  = '0;
      id_wb = '0;
      id_rd = '0;
    end
  end

  assign illegal_id = !reset && inst_valid && !legal_op;
  assign flush_ifid = !reset && branch_taken && !stall_in;

`ifdef HAZARD_DETECT_EN
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic              use_rs2;
  logic              rs_match;

  assign rs1     = inst[15 +: REG_AW];
  assign rs2     = inst[20 +: REG_AW];
  assign use_rs2 = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

  // Every legal opcode reads rs1, so legal_op doubles as the rs1-used flag.
  always_comb begin
    rs_match = 1'b0;
    if (legal_op && rs1 == ex_rd) rs_match = 1'b1;
    if (use_rs2 && rs2 == ex_rd)  rs_match = 1'b1;
  end

  assign hazard_stall = !reset && inst_valid && idex_m[2] && (ex_rd != '0) && rs_match;
`else
  assign hazard_stall = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_ctrl  <= '0;
      idex_m   <= '0;
      idex_wb  <= '0;
      ex_rd    <= '0;
      mem_ctrl <= '0;
      exmem_wb <= '0;
      mem_rd   <= '0;
      wb_ctrl  <= '0;
      wb_rd    <= '0;
    end else if (!stall_in) begin
      wb_ctrl <= exmem_wb;
      wb_rd   <= mem_rd;
      // Flush outranks the load-use bubble; both zero ID/EX.
      if (branch_taken) begin
        ex_ctrl  <= '0;
        idex_m   <= '0;
        idex_wb  <= '0;
        ex_rd    <= '0;
        mem_ctrl <= '0;
        exmem_wb <= '0;
        mem_rd   <= '0;
      end else begin
        mem_ctrl <= idex_m;
        exmem_wb <= idex_wb;
        mem_rd   <= ex_rd;
        if (hazard_stall) begin
          ex_ctrl <= '0;
          idex_m  <= '0;
          idex_wb <= '0;
          ex_rd   <= '0;
        end else begin
          ex_ctrl <= id_ex;
          idex_m  <= id_m;
          idex_wb <= id_wb;
          ex_rd   <= id_rd;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: a table of single instructions
// streamed back-to-back through a scoreboard, plus hand-written sequences
// for reset, load-use, flush and stall corner cases.
module tb_pipe_ctrl_unit;

  localparam logic [31:0] ADD3   = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] LW5    = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] ADDI4  = 32'h00508213; // addi x4,x1,5 (rs2 field = 5, unused)
  localparam logic [31:0] SW     = 32'h0020A423; // sw   x2,8(x1) (rd field = 8)
  localparam logic [31:0] BEQ    = 32'h00208463; // beq  x1,x2,8 (rd field = 8)
  localparam logic [31:0] ADD0   = 32'h00208033; // add  x0,x1,x2
  localparam logic [31:0] ILL    = 32'h0000007F;
  localparam logic [31:0] ADD6   = 32'h00228333; // add  x6,x5,x2
  localparam logic [31:0] LW0    = 32'h0000A003; // lw   x0,0(x1)
  localparam logic [31:0] ADD6X0 = 32'h00200333; // add  x6,x0,x2

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst;
  logic        inst_valid;
  logic        stall_in;
  logic        branch_taken;
  logic [2:0]  ex_ctrl;
  logic [2:0]  mem_ctrl;
  logic [1:0]  wb_ctrl;
  logic [4:0]  ex_rd;
  logic [4:0]  mem_rd;
  logic [4:0]  wb_rd;
  logic        hazard_stall;
  logic        flush_ifid;
  logic        illegal_id;

  pipe_ctrl_unit #(.REG_AW(5), .ILEN(32)) dut (
    .clk(clk), .reset(reset), .inst(inst), .inst_valid(inst_valid),
    .stall_in(stall_in), .branch_taken(branch_taken),
    .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .hazard_stall(hazard_stall), .flush_ifid(flush_ifid), .illegal_id(illegal_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        valid;
    logic [2:0]  ex;
    logic [2:0]  m;
    logic [1:0]  wb;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [2:0] ex;
    logic [2:0] m;
    logic [1:0] wb;
    logic [4:0] rd;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  vec_t tbl[8];
  exp_t ex_q[$];
  exp_t mem_q[$];
  exp_t wb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic v, input logic br, input logic st);
    inst         = i;
    inst_valid   = v;
    branch_taken = br;
    stall_in     = st;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic chk_regs(input string tag, input logic [2:0] e, input logic [4:0] er,
                          input logic [2:0] m, input logic [4:0] mr,
                          input logic [1:0] w, input logic [4:0] wr);
    chk({tag, ".ex_ctrl"},  ex_ctrl,  e);
    chk({tag, ".ex_rd"},    ex_rd,    er);
    chk({tag, ".mem_ctrl"}, mem_ctrl, m);
    chk({tag, ".mem_rd"},   mem_rd,   mr);
    chk({tag, ".wb_ctrl"},  wb_ctrl,  w);
    chk({tag, ".wb_rd"},    wb_rd,    wr);
  endtask

  initial begin
    exp_t e, zero_e;
    zero_e = '{ex: 3'b0, m: 3'b0, wb: 2'b0, rd: 5'd0};

    tbl[0] = '{inst: ADD3,  valid: 1'b1, ex: 3'b010, m: 3'b000, wb: 2'b01, rd: 5'd3, ill: 1'b0};
    tbl[1] = '{inst: LW5,   valid: 1'b1, ex: 3'b100, m: 3'b100, wb: 2'b11, rd: 5'd5, ill: 1'b0};
    tbl[2] = '{inst: ADDI4, valid: 1'b1, ex: 3'b110, m: 3'b000, wb: 2'b01, rd: 5'd4, ill: 1'b0};
    tbl[3] = '{inst: SW,    valid: 1'b1, ex: 3'b100, m: 3'b010, wb: 2'b00, rd: 5'd8, ill: 1'b0};
    tbl[4] = '{inst: BEQ,   valid: 1'b1, ex: 3'b001, m: 3'b001, wb: 2'b00, rd: 5'd8, ill: 1'b0};
    tbl[5] = '{inst: ADD0,  valid: 1'b1, ex: 3'b010, m: 3'b000, wb: 2'b00, rd: 5'd0, ill: 1'b0};
    tbl[6] = '{inst: ILL,   valid: 1'b1, ex: 3'b000, m: 3'b000, wb: 2'b00, rd: 5'd0, ill: 1'b1};
    tbl[7] = '{inst: ADD3,  valid: 1'b0, ex: 3'b000, m: 3'b000, wb: 2'b00, rd: 5'd0, ill: 1'b0};

    // Reset state, with inputs that would otherwise raise the combinational outputs.
    reset = 1'b1;
    drive(ILL, 1'b1, 1'b1, 1'b0);
    step();
    chk_regs("reset", 3'b0, 5'd0, 3'b0, 5'd0, 2'b0, 5'd0);
    chk("reset.flush_ifid", flush_ifid, 1'b0);
    chk("reset.illegal_id", illegal_id, 1'b0);
    chk("reset.hazard", hazard_stall, 1'b0);
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // Table stream through the scoreboard; the empty pipeline supplies the
    // leading zero entries for MEM and WB.
    mem_q.push_back(zero_e);
    wb_q.push_back(zero_e);
    wb_q.push_back(zero_e);
    for (int i = 0; i < 11; i++) begin
      if (i < 8) begin
        drive(tbl[i].inst, tbl[i].valid, 1'b0, 1'b0);
        e = '{ex: tbl[i].ex, m: tbl[i].m, wb: tbl[i].wb, rd: tbl[i].rd};
        #1;
        chk($sformatf("vec%0d.illegal_id", i), illegal_id, tbl[i].ill);
      end else begin
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        e = zero_e;
        #1;
      end
      chk($sformatf("vec%0d.hazard", i), hazard_stall, 1'b0);
      ex_q.push_back(e);
      mem_q.push_back(e);
      wb_q.push_back(e);
      step();
      if (ex_q.size() == 0 || mem_q.size() == 0 || wb_q.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = ex_q.pop_front();
        chk($sformatf("vec%0d.ex_ctrl", i), ex_ctrl, e.ex);
        chk($sformatf("vec%0d.ex_rd", i), ex_rd, e.rd);
        e = mem_q.pop_front();
        chk($sformatf("vec%0d.mem_ctrl", i), mem_ctrl, e.m);
        chk($sformatf("vec%0d.mem_rd", i), mem_rd, e.rd);
        e = wb_q.pop_front();
        chk($sformatf("vec%0d.wb_ctrl", i), wb_ctrl, e.wb);
        chk($sformatf("vec%0d.wb_rd", i), wb_rd, e.rd);
      end
    end

    // Reset mid-run clears everything immediately; first edge after release decodes.
    drive(LW5, 1'b1, 1'b0, 1'b0);
    step();
    drive(ADD3, 1'b1, 1'b0, 1'b0);
    step();
    drive(ILL, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    chk_regs("midreset", 3'b0, 5'd0, 3'b0, 5'd0, 2'b0, 5'd0);
    chk("midreset.flush_ifid", flush_ifid, 1'b0);
    chk("midreset.illegal_id", illegal_id, 1'b0);
    reset = 1'b0;
    drive(ADD3, 1'b1, 1'b0, 1'b0);
    step();
    chk("postreset.ex_ctrl", ex_ctrl, 3'b010);
    chk("postreset.ex_rd", ex_rd, 5'd3);
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk("postreset.mem_ctrl", mem_ctrl, 3'b000);
    chk("postreset.mem_rd", mem_rd, 5'd3);
    step();
    chk("postreset.wb_ctrl", wb_ctrl, 2'b01);
    chk("postreset.wb_rd", wb_rd, 5'd3);

    // Load-use: lw x5 then add x6,x5,x2.
    pulse_reset();
    drive(LW5, 1'b1, 1'b0, 1'b0);
    step();
    drive(ADD6, 1'b1, 1'b0, 1'b0);
    #1;
`ifdef HAZARD_DETECT_EN
    chk("loaduse.hazard", hazard_stall, 1'b1);
    step();
    chk_regs("loaduse.bubble", 3'b000, 5'd0, 3'b100, 5'd5, 2'b00, 5'd0);
    chk("loaduse.hazard_clear", hazard_stall, 1'b0);
    step();
    chk_regs("loaduse.add", 3'b010, 5'd6, 3'b000, 5'd0, 2'b11, 5'd5);
`else
    chk("loaduse.hazard", hazard_stall, 1'b0);
    step();
    chk_regs("loaduse.add", 3'b010, 5'd6, 3'b100, 5'd5, 2'b00, 5'd0);
`endif

    // Load to x0 never stalls.
    pulse_reset();
    drive(LW0, 1'b1, 1'b0, 1'b0);
    step();
    chk("lwx0.ex_ctrl", ex_ctrl, 3'b100);
    drive(ADD6X0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lwx0.hazard", hazard_stall, 1'b0);
    step();
    chk("lwx0.ex_ctrl_add", ex_ctrl, 3'b010);
    chk("lwx0.ex_rd_add", ex_rd, 5'd6);
    step();
    chk("lwx0.wb_ctrl", wb_ctrl, 2'b10);

    // Branch flush: add in MEM, load in EX, store in ID.
    pulse_reset();
    drive(ADD3, 1'b1, 1'b0, 1'b0);
    step();
    drive(LW5, 1'b1, 1'b0, 1'b0);
    step();
    drive(SW, 1'b1, 1'b1, 1'b0);
    #1;
    chk("flush.flush_ifid", flush_ifid, 1'b1);
    step();
    chk_regs("flush", 3'b000, 5'd0, 3'b000, 5'd0, 2'b01, 5'd3);
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("flush.flush_ifid_low", flush_ifid, 1'b0);

    // Flush together with a load-use hazard: the flush zeroes ID/EX and EX/MEM.
    pulse_reset();
    drive(LW5, 1'b1, 1'b0, 1'b0);
    step();
    drive(ADD6, 1'b1, 1'b1, 1'b0);
    step();
    chk_regs("flushhaz", 3'b000, 5'd0, 3'b000, 5'd0, 2'b00, 5'd0);

    // Stall for three cycles with lw, add, sw in flight and a concurrent branch.
    pulse_reset();
    drive(LW5, 1'b1, 1'b0, 1'b0);
    step();
    drive(ADD3, 1'b1, 1'b0, 1'b0);
    step();
    drive(SW, 1'b1, 1'b0, 1'b0);
    step();
    chk_regs("prestall", 3'b100, 5'd8, 3'b000, 5'd3, 2'b11, 5'd5);
    for (int k = 0; k < 3; k++) begin
      drive(BEQ, 1'b1, 1'b1, 1'b1);
      #1;
      chk($sformatf("stall%0d.flush_ifid", k), flush_ifid, 1'b0);
      step();
      chk_regs($sformatf("stall%0d", k), 3'b100, 5'd8, 3'b000, 5'd3, 2'b11, 5'd5);
    end
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk_regs("poststall", 3'b000, 5'd0, 3'b010, 5'd8, 2'b01, 5'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
